// File: rtl/mod_sub_pkg.sv
// Shared types and constants for the chunk-serial modular subtractor.
// Holds the FSM state type, default geometry and the SM2 prime.
package mod_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 256;
    localparam int DEF_CHUNK = 64;
    localparam int N         = DEF_WIDTH / DEF_CHUNK;
    localparam int CNT_W     = (N > 1) ? $clog2(N) : 1;

    localparam logic [255:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    // A single-slice configuration still needs a one-bit counter.
    function automatic int cnt_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/mod_sub_slice.sv
// One CHUNK-bit adder slice; with sub=1 the second operand is inverted so the
// same hardware serves both the subtract pass and the add-back pass.
module mod_sub_slice #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             sub,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK-1:0] y_eff;

    assign y_eff       = sub ? ~y : y;
    assign {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/mod_sub_serial.sv
// Chunk-serial d = (a - b) mod p: one borrow-chain pass over all slices, then
// an add-back pass of p only when the subtraction went negative.
module mod_sub_serial
    import mod_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d
);

    localparam int SLICES           = WIDTH / CHUNK;
    localparam int CW               = cnt_width(SLICES);
    localparam logic [CW-1:0] LAST  = CW'(SLICES - 1);

    state_t state, next_state;

    logic [WIDTH-1:0] a_sh, b_sh, p_sh, d_work;
    logic [CW-1:0]    cnt;
    logic             flag;
    logic             last;

    logic [CHUNK-1:0] slice_x, slice_y, slice_sum;
    logic             slice_sub, slice_cin, slice_cout;

    assign last = (cnt == LAST);

    mod_sub_slice #(.CHUNK(CHUNK)) u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .sub  (slice_sub),
        .cin  (slice_cin),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // The borrow out of the final SUB slice decides whether p must be added back.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = SUB;
            SUB:  if (last)  next_state = slice_cout ? DONE : FIX;
            FIX:  if (last)  next_state = DONE;
            DONE:            next_state = IDLE;
            default:         next_state = IDLE;
        endcase
    end

    // flag is the pending borrow during SUB and the pending carry during FIX.
    always_comb begin
        slice_x   = '0;
        slice_y   = '0;
        slice_sub = 1'b0;
        slice_cin = 1'b0;
        case (state)
            SUB: begin
                slice_x   = a_sh[CHUNK-1:0];
                slice_y   = b_sh[CHUNK-1:0];
                slice_sub = 1'b1;
                slice_cin = ~flag;
            end
            FIX: begin
                slice_x   = d_work[CHUNK-1:0];
                slice_y   = p_sh[CHUNK-1:0];
                slice_cin = flag;
            end
            default: ;
        endcase
    end

    // d_work rotates: each new slice enters at the top, so after SLICES steps
    // the slices sit in their natural order again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            p_sh   <= '0;
            d_work <= '0;
            cnt    <= '0;
            flag   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        p_sh <= p;
                        cnt  <= '0;
                        flag <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                SUB: begin
                    d_work <= {slice_sum, d_work[WIDTH-1:CHUNK]};
                    a_sh   <= a_sh >> CHUNK;
                    b_sh   <= b_sh >> CHUNK;
                    cnt    <= last ? '0 : cnt + CW'(1);
                    flag   <= last ? 1'b0 : ~slice_cout;
                end
                FIX: begin
                    d_work <= {slice_sum, d_work[WIDTH-1:CHUNK]};
                    p_sh   <= p_sh >> CHUNK;
                    cnt    <= last ? '0 : cnt + CW'(1);
                    flag   <= slice_cout;
                end
                DONE: begin
                    d    <= d_work;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_sub_serial.sv
// Directed self-checking bench for mod_sub_serial with hand-computed results
// over the SM2 prime, covering both latency paths, start filtering and reset.
module tb_mod_sub_serial;

    localparam logic [255:0] P    =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] P_M1 =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFE;
    localparam logic [255:0] P_M7 =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFF8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] a = '0;
    logic [255:0] b = '0;
    logic [255:0] p = '0;
    logic         busy;
    logic         done;
    logic [255:0] d;

    int checks = 0;
    int errors = 0;

    mod_sub_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .p     (p),
        .busy  (busy),
        .done  (done),
        .d     (d)
    );

    always #5 clk = ~clk;

    // Runs one operation and reports latency, result and whether busy stayed
    // high from acceptance until done; inputs are scrambled after acceptance.
    task automatic do_op(input logic [255:0] av, input logic [255:0] bv,
                         input logic [255:0] pv, output int lat,
                         output logic [255:0] res, output bit busy_ok);
        @(posedge clk); #1;
        a = av; b = bv; p = pv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = '1; b = '0; p = '0;
        busy_ok = (busy === 1'b1);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 0;
        end
        if (busy !== 1'b0) busy_ok = 0;
        res = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || d !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: busy=%b done=%b d=%h, want 0 0 0", busy, done, d);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat; logic [255:0] res; bit bok;
        do_op(256'd10, 256'd3, P, lat, res, bok);
        checks++;
        if (res !== 256'd7) begin
            errors++; $display("[TB] FAIL basic_d: got %h want %h", res, 256'd7);
        end
        checks++;
        if (lat !== 5) begin
            errors++; $display("[TB] FAIL basic_latency: got %0d want 5", lat);
        end
        checks++;
        if (!bok) begin
            errors++; $display("[TB] FAIL basic_busy: got window_ok=0 want 1");
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || d !== 256'd7) begin
            errors++; $display("[TB] FAIL basic_pulse_hold: done=%b d=%h want 0 and 7", done, d);
        end
    endtask

    task automatic test_wrap();
        int lat; logic [255:0] res; bit bok;
        do_op(256'd3, 256'd10, P, lat, res, bok);
        checks++;
        if (res !== P_M7) begin
            errors++; $display("[TB] FAIL wrap_d: got %h want %h", res, P_M7);
        end
        checks++;
        if (lat !== 9) begin
            errors++; $display("[TB] FAIL wrap_latency: got %0d want 9", lat);
        end
        checks++;
        if (!bok) begin
            errors++; $display("[TB] FAIL wrap_busy: got window_ok=0 want 1");
        end
    endtask

    task automatic test_boundaries();
        int lat; logic [255:0] res; bit bok;
        do_op(P_M1, P_M1, P, lat, res, bok);
        checks++;
        if (res !== '0 || lat !== 5) begin
            errors++; $display("[TB] FAIL equal_operands: got d=%h lat=%0d want 0 lat=5", res, lat);
        end
        do_op(256'd0, 256'd1, P, lat, res, bok);
        checks++;
        if (res !== P_M1 || lat !== 9) begin
            errors++; $display("[TB] FAIL zero_minus_one: got d=%h lat=%0d want %h lat=9", res, lat, P_M1);
        end
    endtask

    task automatic test_borrow_chain();
        int lat; logic [255:0] res; bit bok;
        logic [255:0] av;
        av = 256'd1 << 64;
        do_op(av, 256'd1, P, lat, res, bok);
        checks++;
        if (res !== 256'hFFFFFFFF_FFFFFFFF || lat !== 5) begin
            errors++; $display("[TB] FAIL borrow_64: got d=%h lat=%0d want 2^64-1 lat=5", res, lat);
        end
        av = 256'd1 << 192;
        do_op(av, 256'd1, P, lat, res, bok);
        checks++;
        if (res !== 256'h00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF
            || lat !== 5) begin
            errors++; $display("[TB] FAIL borrow_192: got d=%h lat=%0d want 2^192-1 lat=5", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int pulses; int first_lat;
        logic [255:0] first_d;
        @(posedge clk); #1;
        a = 256'd10; b = 256'd3; p = P; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; a = 256'd3; b = 256'd10; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || d !== 256'd7) begin
            errors++; $display("[TB] FAIL b2b_first_result: done=%b d=%h want 1 and 7", done, d);
        end
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_idle_accept: busy=%b done=%b want 1 0", busy, done);
        end
        pulses = 0; first_lat = 0; first_d = '0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) begin first_lat = i; first_d = d; end
            end
        end
        checks++;
        if (pulses !== 1 || first_lat !== 9 || first_d !== P_M7) begin
            errors++;
            $display("[TB] FAIL b2b_second_op: pulses=%0d lat=%0d d=%h want 1 9 %h",
                     pulses, first_lat, first_d, P_M7);
        end
    endtask

    task automatic test_async_reset();
        int lat; int pulses; logic [255:0] res; bit bok;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            a = 256'd3; b = 256'd10; p = P; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            repeat ((k == 0) ? 2 : 6) @(posedge clk);
            #4 rst_n = 1'b0;
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || d !== '0) begin
                errors++;
                $display("[TB] FAIL async_reset_%0d: busy=%b done=%b d=%h want 0 0 0", k, busy, done, d);
            end
            @(posedge clk); #1 rst_n = 1'b1;
            pulses = 0;
            repeat (15) begin
                @(posedge clk); #1;
                if (done === 1'b1) pulses++;
            end
            checks++;
            if (pulses !== 0) begin
                errors++; $display("[TB] FAIL abandoned_done_%0d: got %0d pulses want 0", k, pulses);
            end
        end
        do_op(256'd10, 256'd3, P, lat, res, bok);
        checks++;
        if (res !== 256'd7 || lat !== 5 || !bok) begin
            errors++; $display("[TB] FAIL after_reset_op: d=%h lat=%0d busy_ok=%0d want 7 5 1", res, lat, bok);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_boundaries();
        test_borrow_chain();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
